// File: rtl/led_fader_if.sv
// Connection bundle between the blink stage and the LED fader.
// The master side drives the target LED state; the slave side (the fader)
// returns the PWM drive, the current brightness and the ramping flag.
interface led_fader_if #(
  parameter int unsigned PWM_W = 32'd8
) ();
  logic             led_i;
  logic             led_o;
  logic [PWM_W-1:0] level_o;
  logic             busy_o;

  modport master (
    output led_i,
    input  led_o,
    input  level_o,
    input  busy_o
  );

  modport slave (
    input  led_i,
    output led_o,
    output level_o,
    output busy_o
  );
endinterface

// File: rtl/led_fader.sv
// LED fader: turns each on/off change of the blink stage output into a
// linear brightness ramp and drives the LED pin with a PWM waveform whose
// duty is only updated at PWM period boundaries.
module led_fader #(
  parameter int unsigned FREQ    = 32'd0,
  parameter int unsigned RAMP_MS = 32'd0,
  parameter int unsigned PWM_W   = 32'd8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  led_fader_if.slave bus
);

  localparam logic [PWM_W-1:0] MAX = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] ONE = PWM_W'(1'b1);

  // Cycles per brightness step; a ramp too short to resolve steps one per
  // cycle degenerates to one step per clock.
  localparam logic [63:0] STEP_RAW =
    (64'(FREQ) * 64'(RAMP_MS)) / (64'd1000 * 64'(MAX));
  localparam int unsigned STEP_DIV = (STEP_RAW == 64'd0) ? 32'd1 : 32'(STEP_RAW);
  localparam int unsigned CNT_W    = (STEP_DIV > 32'd1) ? $clog2(STEP_DIV) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [PWM_W-1:0] level;
  logic [PWM_W-1:0] level_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             busy;
  logic             busy_nx;
  logic             tick;
  logic [PWM_W-1:0] pwm;
  logic [PWM_W-1:0] duty;
  logic             led;

  assign tick = (cnt == CNT_LAST);

  // A zero clock frequency or ramp length is a configuration error
  always_comb begin
    assert (FREQ != 32'd0) else $fatal(1, "led_fader: FREQ must be nonzero");
    assert (RAMP_MS != 32'd0) else $fatal(1, "led_fader: RAMP_MS must be nonzero");
  end

  // Ramp FSM: next state, next level and step-counter update
  always_comb begin
    state_nx = state;
    level_nx = level;
    cnt_nx   = CNT_ZERO;
    case (state)
      ST_OFF: begin
        if (bus.led_i) state_nx = ST_RISE;
        else           state_nx = ST_OFF;
      end
      ST_RISE: begin
        // A reversal beats a coincident tick: level holds, direction flips.
        if (!bus.led_i) begin
          state_nx = ST_FALL;
        end else if (tick) begin
          if (level != MAX)      level_nx = level + ONE;
          else                   level_nx = level;
          if (level >= MAX - ONE) state_nx = ST_ON;
          else                    state_nx = ST_RISE;
        end else begin
          state_nx = ST_RISE;
        end
      end
      ST_ON: begin
        if (!bus.led_i) state_nx = ST_FALL;
        else            state_nx = ST_ON;
      end
      ST_FALL: begin
        if (bus.led_i) begin
          state_nx = ST_RISE;
        end else if (tick) begin
          if (level != {PWM_W{1'b0}}) level_nx = level - ONE;
          else                        level_nx = level;
          if (level <= ONE) state_nx = ST_OFF;
          else              state_nx = ST_FALL;
        end else begin
          state_nx = ST_FALL;
        end
      end
      default: begin
        state_nx = ST_OFF;
        level_nx = {PWM_W{1'b0}};
      end
    endcase

    // Every state change restarts the step timing from zero.
    if (state_nx != state) cnt_nx = CNT_ZERO;
    else if (tick)         cnt_nx = CNT_ZERO;
    else                   cnt_nx = cnt + CNT_ONE;

    busy_nx = (state_nx == ST_RISE) || (state_nx == ST_FALL);
  end

  // Ramp FSM registers: state, level, step counter and busy flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_OFF;
      level <= {PWM_W{1'b0}};
      cnt   <= CNT_ZERO;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
    end
  end

  // PWM: free-running period counter, duty latched at the period boundary
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm  <= {PWM_W{1'b0}};
      duty <= {PWM_W{1'b0}};
      led  <= 1'b0;
    end else begin
      pwm <= pwm + ONE;
      if (pwm == MAX) duty <= level;
      else            duty <= duty;
      led <= (duty == MAX) || (pwm < duty);
    end
  end

  assign bus.led_o   = led;
  assign bus.level_o = level;
  assign bus.busy_o  = busy;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader: a cycle-level reference model of the
// brightness ramp and PWM output pushes expected values per clock edge,
// and an independent monitor pops and compares them on the falling edge.
module tb_led_fader;

  localparam int unsigned PW   = 32'd4;
  localparam int          MAXV = 15;
  localparam int          SD   = 4;
  localparam int          PER  = 16;

  typedef struct {
    int lvl;
    bit busy;
    bit led;
    bit wend;
    int duty;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Reference model state
  int m_lvl, m_age, m_p, m_lat;
  bit m_head, m_busy, m_led;

  always #5 clk = ~clk;

  led_fader_if #(.PWM_W(PW)) bus ();
  led_fader_if #(.PWM_W(PW)) bus1 ();

  led_fader #(.FREQ(15000), .RAMP_MS(4), .PWM_W(PW)) u_dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  led_fader #(.FREQ(1000), .RAMP_MS(1), .PWM_W(PW)) u_dut1 (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus1)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_lvl = 0; m_age = 0; m_p = 0; m_lat = 0;
    m_head = 1'b0; m_busy = 1'b0; m_led = 1'b0;
  endfunction

  // One clock edge of the reference: v is the LED target sampled there.
  function automatic void model_edge(input bit v);
    exp_t e;
    e.wend = (m_p == MAXV);
    e.duty = (m_lat == MAXV) ? PER : m_lat;
    m_led  = (m_lat == MAXV) || (m_p < m_lat);
    if (m_p == MAXV) m_lat = m_lvl;
    m_p = (m_p + 1) % PER;
    if (v != m_head) begin
      m_head = v;
      m_busy = 1'b1;
      m_age  = 0;
    end else if (m_busy) begin
      m_age++;
      if (m_age == SD) begin
        m_age = 0;
        if (m_head) begin
          if (m_lvl >= MAXV - 1) m_busy = 1'b0;
          if (m_lvl < MAXV) m_lvl++;
        end else begin
          if (m_lvl <= 1) m_busy = 1'b0;
          if (m_lvl > 0) m_lvl--;
        end
      end
    end
    e.lvl  = m_lvl;
    e.busy = m_busy;
    e.led  = m_led;
    q.push_back(e);
  endfunction

  task automatic step(input bit v);
    bus.led_i = v;
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  // Monitor: compare every edge's outputs and each PWM period's high count
  initial begin : monitor
    int   acc;
    exp_t e;
    acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        acc = 0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("level", int'(bus.level_o), e.lvl);
        chk("busy", int'(bus.busy_o), int'(e.busy));
        chk("led", int'(bus.led_o), int'(e.led));
        acc += int'(bus.led_o);
        if (e.wend) begin
          chk("duty_count", acc, e.duty);
          acc = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int lv;
    int n;
    bit v;
    bus.led_i  = 1'b0;
    bus1.led_i = 1'b0;
    model_reset();

    // Reset held with the input toggling: everything stays at zero.
    for (int i = 0; i < 50; i++) begin
      bus.led_i  = i[0];
      bus1.led_i = ~i[0];
      @(posedge clk); #1;
      chk("rst_level", int'(bus.level_o), 0);
      chk("rst_busy", int'(bus.busy_o), 0);
      chk("rst_led", int'(bus.led_o), 0);
    end
    bus.led_i  = 1'b0;
    bus1.led_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;

    // Full rise on both instances; the fast one steps every cycle.
    bus1.led_i = 1'b1;
    for (int j = 1; j <= 80; j++) begin
      step(1'b1);
      if (j <= 20) begin
        chk("fast_level", int'(bus1.level_o), (j - 1 > MAXV) ? MAXV : j - 1);
        chk("fast_busy", int'(bus1.busy_o), int'(j < 16));
      end
      if (j == 60) begin
        chk("rise_e59_busy", int'(bus.busy_o), 1);
        chk("rise_e59_level", int'(bus.level_o), 14);
      end
      if (j == 61) begin
        chk("rise_e60_busy", int'(bus.busy_o), 0);
        chk("rise_e60_level", int'(bus.level_o), 15);
      end
    end
    repeat (40) step(1'b1);
    repeat (70) step(1'b0);

    // Reversal during a rise at level 6.
    for (int g = 0; g < 200 && m_lvl < 6; g++) step(1'b1);
    chk("rev_at6", int'(bus.level_o), 6);
    repeat (40) step(1'b0);

    // Reversal on the very edge that would otherwise have stepped up.
    for (int g = 0; g < 200 && !(m_lvl >= 3 && m_age == SD - 1); g++) step(1'b1);
    lv = int'(bus.level_o);
    step(1'b0);
    chk("tick_rev_hold", int'(bus.level_o), lv);
    chk("tick_rev_busy", int'(bus.busy_o), 1);
    repeat (70) step(1'b0);

    // Asynchronous reset mid-rise at level 7 clears outputs before any edge.
    for (int g = 0; g < 200 && m_lvl < 7; g++) step(1'b1);
    @(negedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("async_level", int'(bus.level_o), 0);
    chk("async_busy", int'(bus.busy_o), 0);
    chk("async_led", int'(bus.led_o), 0);
    chk("async_fast_level", int'(bus1.level_o), 0);
    chk("async_fast_led", int'(bus1.led_o), 0);
    model_reset();
    bus.led_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_ni = 1'b1;

    // Random hold lengths for the LED target.
    for (int k = 0; k < 40; k++) begin
      v = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 80));
      repeat (n) step(v);
    end

    for (int g = 0; g < 10 && q.size() > 0; g++) @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
